// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES-128 key schedule:
//   word_t   - 32-bit schedule word (w0..w3), MSB byte first
//   state_t  - key schedule FSM states (PRECOMP exists only when
//              AES_KEY_SCHED_INV_EN is defined)
//   RCON     - round constants for rounds 1..10 (index 0 = round 1)
//   SBOX     - forward AES S-box table used by aes_sbox
// Configuration macro: AES_KEY_SCHED_INV_EN (adds the inverse-order state).
// -----------------------------------------------------------------------------
package aes_pkg;

    typedef logic [31:0] word_t;

`ifdef AES_KEY_SCHED_INV_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EMIT    = 2'd1,
        PRECOMP = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EMIT    = 2'd1
    } state_t;
`endif

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/aes_sbox.sv
// -----------------------------------------------------------------------------
// aes_sbox
// Forward AES S-box, purely combinational table lookup.
// Ports:
//   a - input byte
//   y - substituted byte
// -----------------------------------------------------------------------------
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    assign y = SBOX[a];

endmodule

// File: rtl/aes_sub_word.sv
// -----------------------------------------------------------------------------
// aes_sub_word
// SubWord: applies the AES S-box to each byte of a 32-bit word.
// Purely combinational.
// Ports:
//   w - input word
//   s - substituted word
// -----------------------------------------------------------------------------
module aes_sub_word
    import aes_pkg::*;
(
    input  word_t w,
    output word_t s
);

    for (genvar i = 0; i < 4; i++) begin : g_byte
        aes_sbox u_sbox (
            .a (w[8*i +: 8]),
            .y (s[8*i +: 8])
        );
    end

endmodule

// File: rtl/aes128_key_sched.sv
// -----------------------------------------------------------------------------
// aes128_key_sched
// AES-128 round key generator. After a one-cycle start in IDLE it presents
// round keys 0..10 one at a time on rk, each held until accepted.
//
// Handshake: rk/round_idx are valid while rk_valid=1; a key is consumed in a
// cycle where rk_valid=1 and rk_ready=1, and while rk_valid=1 and rk_ready=0
// rk, round_idx and rk_valid stay unchanged. rk is a pure register output.
//
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   start, key_in    - begin a schedule from key_in (only honoured in IDLE)
//   dir              - (AES_KEY_SCHED_INV_EN only) 0 = rounds 0..10,
//                      1 = rounds 10..0 after a 10-cycle precompute
//   rk_ready         - consumer accepts the current round key
//   rk, rk_valid     - current round key and its valid flag
//   round_idx        - round number of rk
//   busy             - high whenever the FSM is not IDLE
//   state_dbg        - raw FSM state for observation
// Configuration macro: AES_KEY_SCHED_INV_EN (adds dir and inverse order).
// -----------------------------------------------------------------------------
module aes128_key_sched
    import aes_pkg::*;
#(
    parameter int NR = 10
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
`ifdef AES_KEY_SCHED_INV_EN
    input  logic         dir,
`endif
    input  logic         rk_ready,
    output logic [127:0] rk,
    output logic         rk_valid,
    output logic [3:0]   round_idx,
    output logic         busy,
    output logic [1:0]   state_dbg
);

    localparam logic [3:0] LAST = 4'(NR);

    state_t       state_q, state_d;
    logic [127:0] rk_d;
    logic [3:0]   idx_d;
    logic         valid_d;

    word_t w0, w1, w2, w3;
    word_t sub_in, sub_out;
    word_t f0, f1, f2, f3;
    logic [3:0]   rc_sel;
    logic [7:0]   rc;
    logic [127:0] fwd_key;
    logic [127:0] step_key;
    logic [3:0]   step_idx;
    logic         last_key;

    assign {w0, w1, w2, w3} = rk;

`ifdef AES_KEY_SCHED_INV_EN
    logic  dir_q, dir_d;
    logic  use_inv;
    word_t v1, v2, v3;

    // Precompute always steps forward; only EMIT in inverse mode walks back.
    assign use_inv = (state_q == EMIT) && dir_q;
    assign v3 = w3 ^ w2;
    assign v2 = w2 ^ w1;
    assign v1 = w1 ^ w0;
    assign sub_in   = use_inv ? {v3[23:0], v3[31:24]} : {w3[23:0], w3[31:24]};
    // Forward from round r uses Rcon[r+1] (table index r); backward from
    // round r uses Rcon[r] (table index r-1).
    assign rc_sel   = use_inv ? (round_idx - 4'd1) : round_idx;
    assign step_key = use_inv ? {w0 ^ sub_out ^ {rc, 24'h0}, v1, v2, v3} : fwd_key;
    assign step_idx = use_inv ? (round_idx - 4'd1) : (round_idx + 4'd1);
    assign last_key = use_inv ? (round_idx == 4'd0) : (round_idx == LAST);
`else
    assign sub_in   = {w3[23:0], w3[31:24]};
    assign rc_sel   = round_idx;
    assign step_key = fwd_key;
    assign step_idx = round_idx + 4'd1;
    assign last_key = (round_idx == LAST);
`endif

    assign rc = (rc_sel < 4'd10) ? RCON[rc_sel] : 8'h00;

    // Single SubWord shared by forward and backward steps.
    aes_sub_word u_sub_word (
        .w (sub_in),
        .s (sub_out)
    );

    assign f0 = w0 ^ sub_out ^ {rc, 24'h0};
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;
    assign fwd_key = {f0, f1, f2, f3};

    always_comb begin
        state_d = state_q;
        rk_d    = rk;
        idx_d   = round_idx;
        valid_d = rk_valid;
`ifdef AES_KEY_SCHED_INV_EN
        dir_d   = dir_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    rk_d  = key_in;
                    idx_d = 4'd0;
`ifdef AES_KEY_SCHED_INV_EN
                    dir_d = dir;
                    if (dir) begin
                        state_d = PRECOMP;
                        valid_d = 1'b0;
                    end else begin
                        state_d = EMIT;
                        valid_d = 1'b1;
                    end
`else
                    state_d = EMIT;
                    valid_d = 1'b1;
`endif
                end
            end
            EMIT: begin
                if (rk_valid && rk_ready) begin
                    if (last_key) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end else begin
                        rk_d  = step_key;
                        idx_d = step_idx;
                    end
                end
            end
`ifdef AES_KEY_SCHED_INV_EN
            PRECOMP: begin
                // Ten forward steps bring rk to round key 10.
                rk_d  = fwd_key;
                idx_d = round_idx + 4'd1;
                if (round_idx == LAST - 4'd1) begin
                    state_d = EMIT;
                    valid_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rk        <= '0;
            round_idx <= 4'd0;
            rk_valid  <= 1'b0;
`ifdef AES_KEY_SCHED_INV_EN
            dir_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rk        <= rk_d;
            round_idx <= idx_d;
            rk_valid  <= valid_d;
`ifdef AES_KEY_SCHED_INV_EN
            dir_q     <= dir_d;
`endif
        end
    end

    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_aes128_key_sched.sv
// -----------------------------------------------------------------------------
// tb_aes128_key_sched
// Directed bench for aes128_key_sched using the FIPS-197 example key.
// Define AES_KEY_SCHED_INV_EN for both bench and RTL to include inverse order.
// -----------------------------------------------------------------------------
module tb_aes128_key_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         dir;
    logic         rk_ready;
    logic [127:0] rk;
    logic         rk_valid;
    logic [3:0]   round_idx;
    logic         busy;
    logic [1:0]   state_dbg;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY2 = 128'h0;
    localparam logic [127:0] KEY2_R1 = 128'h62636363626363636263636362636363;

    logic [127:0] exp_rk [11];

    always #5 clk = ~clk;

    aes128_key_sched #(.NR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
`ifdef AES_KEY_SCHED_INV_EN
        .dir       (dir),
`endif
        .rk_ready  (rk_ready),
        .rk        (rk),
        .rk_valid  (rk_valid),
        .round_idx (round_idx),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_key(input string tag, input int r);
        check($sformatf("%s rk r%0d", tag, r), rk, exp_rk[r]);
        check($sformatf("%s idx r%0d", tag, r), 128'(round_idx), 128'(r));
        check($sformatf("%s valid r%0d", tag, r), 128'(rk_valid), 128'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        logic rdy;

        exp_rk[0]  = KEY;
        exp_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        // Reset state
        rst = 1'b1; start = 1'b0; key_in = '0; dir = 1'b0; rk_ready = 1'b0;
        tick();
        tick();
        check("reset rk", rk, 128'h0);
        check("reset valid", 128'(rk_valid), 128'd0);
        check("reset busy", 128'(busy), 128'd0);
        check("reset idx", 128'(round_idx), 128'd0);
        rst = 1'b0;
        tick();

        // Forward schedule, continuous ready
        key_in = KEY; start = 1'b1;
        tick();
        start = 1'b0; key_in = '1; rk_ready = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            check_key("fwd", i);
            check($sformatf("fwd busy r%0d", i), 128'(busy), 128'd1);
            tick();
        end
        check("fwd end valid", 128'(rk_valid), 128'd0);
        check("fwd end busy", 128'(busy), 128'd0);

        // Back-to-back start the cycle after the final handshake
        key_in = KEY; start = 1'b1; rk_ready = 1'b0;
        tick();
        start = 1'b0; key_in = '0;
        check_key("b2b", 0);

        // Backpressure on the same schedule
        k = 0;
        for (int cyc = 0; cyc < 300 && k <= 10; cyc++) begin
            rdy = 1'($urandom_range(0, 1));
            rk_ready = rdy;
            check_key("bp", k);
            tick();
            if (rdy) k++;
        end
        check("bp key count", 128'(k), 128'd11);
        rk_ready = 1'b0;
        check("bp end valid", 128'(rk_valid), 128'd0);

        // Start while busy is ignored
        key_in = KEY; start = 1'b1;
        tick();
        start = 1'b0; rk_ready = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            if (i == 3) begin
                start = 1'b1; key_in = KEY2;
            end else begin
                start = 1'b0;
            end
            check_key("busy_start", i);
            tick();
        end
        start = 1'b0;
        check("busy_start end valid", 128'(rk_valid), 128'd0);

        // Reset mid-schedule after round 4 is accepted; start during reset ignored
        key_in = KEY; start = 1'b1;
        tick();
        start = 1'b0; rk_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            check_key("mid", i);
            tick();
        end
        check_key("mid", 5);
        rst = 1'b1; start = 1'b1; key_in = KEY2;
        tick();
        check("midrst rk", rk, 128'h0);
        check("midrst valid", 128'(rk_valid), 128'd0);
        check("midrst busy", 128'(busy), 128'd0);
        check("midrst idx", 128'(round_idx), 128'd0);
        rst = 1'b0; start = 1'b0;
        tick();
        check("after rst valid", 128'(rk_valid), 128'd0);
        check("after rst busy", 128'(busy), 128'd0);
        key_in = KEY2; start = 1'b1; rk_ready = 1'b0;
        tick();
        start = 1'b0;
        check("restart rk0", rk, KEY2);
        check("restart idx0", 128'(round_idx), 128'd0);
        check("restart valid0", 128'(rk_valid), 128'd1);
        rk_ready = 1'b1;
        tick();
        check("restart rk1", rk, KEY2_R1);
        check("restart idx1", 128'(round_idx), 128'd1);
        for (int i = 0; i < 20 && rk_valid; i++) tick();
        check("restart end valid", 128'(rk_valid), 128'd0);
        rk_ready = 1'b0;

`ifdef AES_KEY_SCHED_INV_EN
        // Inverse order
        key_in = KEY; dir = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; dir = 1'b0; key_in = '0; rk_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("inv pre busy c%0d", i), 128'(busy), 128'd1);
            check($sformatf("inv pre valid c%0d", i), 128'(rk_valid), 128'd0);
            tick();
        end
        for (int i = 10; i >= 0; i--) begin
            check_key("inv", i);
            tick();
        end
        check("inv end valid", 128'(rk_valid), 128'd0);
        check("inv end busy", 128'(busy), 128'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
